// File: rtl/uart_tx_drain.sv
// UART transmitter that pops words from a first-word-fall-through FIFO
// and serialises them with an internal 16x-oversample baud generator.
module uart_tx_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int S_W = (SB_TICK > 16) ? 5 : 4;
    localparam int N_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [S_W-1:0] S_LAST = S_W'(15);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_WIDTH - 1);

    logic [1:0]            state, state_next;
    logic [DVSR_WIDTH-1:0] b_cnt;
    logic [S_W-1:0]        s_cnt, s_cnt_next;
    logic [N_W-1:0]        n_cnt, n_cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic                  tx_reg, tx_next;
    logic                  tick;
    logic                  pop, done;

    assign tick = (state != IDLE) && (b_cnt == dvsr);

    always_comb begin
        state_next = state;
        s_cnt_next = s_cnt;
        n_cnt_next = n_cnt;
        shift_next = shift;
        pop        = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = r_data;
                    s_cnt_next = '0;
                    n_cnt_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_next = '0;
                        state_next = DATA;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == S_LAST) begin
                        s_cnt_next = '0;
                        shift_next = shift >> 1;
                        if (n_cnt == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_cnt_next = n_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == S_STOP) begin
                        done       = 1'b1;
                        s_cnt_next = '0;
                        state_next = IDLE;
                    end else begin
                        s_cnt_next = s_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The pin level follows the state being entered, so it moves with the state edge.
    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            b_cnt  <= '0;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shift  <= '0;
            tx_reg <= 1'b1;
        end else begin
            state  <= state_next;
            s_cnt  <= s_cnt_next;
            n_cnt  <= n_cnt_next;
            shift  <= shift_next;
            tx_reg <= tx_next;
            if (state == IDLE || tick) begin
                b_cnt <= '0;
            end else begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end

    // Strobes are masked while reset is held so nothing is popped or reported.
    assign rd           = reset & pop;
    assign tx_done_tick = reset & done;
    assign tx           = tx_reg;
    assign tx_busy      = (state != IDLE);

endmodule
